rf_seq: RTL and testbench



---
 rtl/nes_cpu_pkg.sv | 35 +++
 rtl/rf_seq_alu.sv | 25 ++
 rtl/rf_seq.sv | 156 +++++++++++++++
 tb/tb_rf_seq.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/nes_cpu_pkg.sv
// Shared CPU definitions: register ids, RF micro-op codes, flag bit positions.
// Also holds the sequencer state encoding used by rf_seq.
package nes_cpu_pkg;

    localparam int BYTE = 8;

    localparam int FLAG_N_BIT = 7;
    localparam int FLAG_Z_BIT = 1;

    typedef enum logic [2:0] {
        REG_A = 3'd0,
        REG_X = 3'd1,
        REG_Y = 3'd2,
        REG_S = 3'd3,
        REG_T = 3'd4
    } reg_id_t;

    typedef enum logic [1:0] {
        OP_MOV = 2'd0,
        OP_INC = 2'd1,
        OP_DEC = 2'd2,
        OP_RSV = 2'd3
    } rf_op_t;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_READ  = 2'd1,
        SEQ_WRITE = 2'd2
    } seq_state_t;

    function automatic logic id_legal(input logic [2:0] id, input int num_regs);
        return int'(id) < num_regs;
    endfunction

endpackage

// File: rtl/rf_seq_alu.sv
// Combinational byte ALU for register-to-register micro-ops (modulo-256).
// Shared with the ALU flag path; the reserved opcode behaves as MOV.
module rf_seq_alu
    import nes_cpu_pkg::*;
(
    input  rf_op_t          op_i,
    input  logic [BYTE-1:0] tmp_i,
    output logic [BYTE-1:0] result_o,
    output logic            n_flag_o,
    output logic            z_flag_o
);

    always_comb begin
        result_o = tmp_i;
        case (op_i)
            OP_INC:  result_o = tmp_i + 8'd1;
            OP_DEC:  result_o = tmp_i - 8'd1;
            default: result_o = tmp_i;
        endcase
    end

    assign n_flag_o = result_o[BYTE-1];
    assign z_flag_o = (result_o == '0);

endmodule

// File: rtl/rf_seq.sv
// Register-file port sequencer: runs MOV/INC/DEC as a read cycle then a write cycle.
// Build option RF_SEQ_FLAGS_EN adds N/Z status updates on legal non-S writes.
//
// state     | meaning
// SEQ_IDLE  | port parked at address 0, ready for a request
// SEQ_READ  | source on the port, read data captured at the edge
// SEQ_WRITE | destination written, done pulse, may accept the next op
module rf_seq
    import nes_cpu_pkg::*;
#(
    parameter int NUM_REGS = 5
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  rf_op_t          req_op_i,
    input  reg_id_t         req_src_i,
    input  reg_id_t         req_dst_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            err_o,
    output reg_id_t         rf_addr_o,
    output logic            rf_we_o,
    output logic [BYTE-1:0] rf_wdata_o,
    input  logic [BYTE-1:0] rf_rdata_i,
    input  logic [BYTE-1:0] status_i,
    output logic            status_we_o,
    output logic [BYTE-1:0] status_o
);

    seq_state_t      state_q;
    rf_op_t          op_q;
    reg_id_t         src_q;
    reg_id_t         dst_q;
    logic            illegal_q;

    logic            ready_q;
    logic            busy_q;
    logic            done_q;
    logic            err_q;
    reg_id_t         addr_q;
    logic            we_q;
    logic [BYTE-1:0] wdata_q;

    logic            req_legal;
    logic [BYTE-1:0] alu_result;
    logic            alu_n;
    logic            alu_z;

    assign req_legal = id_legal(req_src_i, NUM_REGS) && id_legal(req_dst_i, NUM_REGS);

    // The ALU works on the live read data during READ; its result is what gets captured.
    rf_seq_alu u_alu (
        .op_i     (op_q),
        .tmp_i    (rf_rdata_i),
        .result_o (alu_result),
        .n_flag_o (alu_n),
        .z_flag_o (alu_z)
    );

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= SEQ_IDLE;
            op_q      <= OP_MOV;
            src_q     <= REG_A;
            dst_q     <= REG_A;
            illegal_q <= 1'b0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            addr_q    <= REG_A;
            we_q      <= 1'b0;
            wdata_q   <= '0;
        end else begin
            case (state_q)
                SEQ_READ: begin
                    state_q <= SEQ_WRITE;
                    wdata_q <= alu_result;
                    addr_q  <= illegal_q ? REG_A : dst_q;
                    we_q    <= !illegal_q;
                    done_q  <= 1'b1;
                    err_q   <= illegal_q;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b1;
                end
                default: begin
                    // IDLE and WRITE share the accept path, giving one op per two cycles.
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    we_q    <= 1'b0;
                    wdata_q <= '0;
                    if (req_valid_i) begin
                        state_q   <= SEQ_READ;
                        op_q      <= req_op_i;
                        src_q     <= req_src_i;
                        dst_q     <= req_dst_i;
                        illegal_q <= !req_legal;
                        addr_q    <= req_legal ? req_src_i : REG_A;
                        ready_q   <= 1'b0;
                        busy_q    <= 1'b1;
                    end else begin
                        state_q <= SEQ_IDLE;
                        addr_q  <= REG_A;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign req_ready_o = ready_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign rf_addr_o   = addr_q;
    assign rf_we_o     = we_q;
    assign rf_wdata_o  = wdata_q;

`ifdef RF_SEQ_FLAGS_EN
    logic            stwe_q;
    logic [BYTE-1:0] stat_q;
    logic [BYTE-1:0] stat_upd;

    always_comb begin
        stat_upd             = status_i;
        stat_upd[FLAG_N_BIT] = alu_n;
        stat_upd[FLAG_Z_BIT] = alu_z;
    end

    // A write to S is a stack-pointer transfer and leaves the flags alone.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            stwe_q <= 1'b0;
            stat_q <= '0;
        end else if (state_q == SEQ_READ && !illegal_q && dst_q != REG_S) begin
            stwe_q <= 1'b1;
            stat_q <= stat_upd;
        end else begin
            stwe_q <= 1'b0;
            stat_q <= '0;
        end
    end

    assign status_we_o = stwe_q;
    assign status_o    = stat_q;
`else
    logic unused_flags;
    assign unused_flags = ^{status_i, alu_n, alu_z};
    assign status_we_o  = 1'b0;
    assign status_o     = '0;
`endif

endmodule

// File: tb/tb_rf_seq.sv
// Self-checking bench for rf_seq with a behavioural 5-entry register file.
// Flag expectations follow RF_SEQ_FLAGS_EN when that macro is defined.
module tb_rf_seq;
    import nes_cpu_pkg::*;

    logic       clk_i = 1'b0;
    logic       rstn_i = 1'b0;
    logic       req_valid_i = 1'b0;
    logic       req_ready_o;
    rf_op_t     req_op_i = OP_MOV;
    reg_id_t    req_src_i = REG_A;
    reg_id_t    req_dst_i = REG_A;
    logic       busy_o, done_o, err_o;
    reg_id_t    rf_addr_o;
    logic       rf_we_o;
    logic [7:0] rf_wdata_o;
    logic [7:0] rf_rdata_i;
    logic [7:0] status_i = 8'h00;
    logic       status_we_o;
    logic [7:0] status_o;

    logic [7:0] rf_mem [5];
    logic       load_en = 1'b0;
    int         load_idx = 0;
    logic [7:0] load_val = 8'h00;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk_i = ~clk_i;

    rf_seq #(.NUM_REGS(5)) dut (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_op_i    (req_op_i),
        .req_src_i   (req_src_i),
        .req_dst_i   (req_dst_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .rf_addr_o   (rf_addr_o),
        .rf_we_o     (rf_we_o),
        .rf_wdata_o  (rf_wdata_o),
        .rf_rdata_i  (rf_rdata_i),
        .status_i    (status_i),
        .status_we_o (status_we_o),
        .status_o    (status_o)
    );

    assign rf_rdata_i = (int'(rf_addr_o) < 5) ? rf_mem[int'(rf_addr_o)] : 8'h00;

    always @(posedge clk_i) begin
        if (load_en)
            rf_mem[load_idx] <= load_val;
        else if (rf_we_o && int'(rf_addr_o) < 5)
            rf_mem[int'(rf_addr_o)] <= rf_wdata_o;
    end

    typedef struct {
        rf_op_t     op;
        reg_id_t    src;
        reg_id_t    dst;
        logic [7:0] init;
        logic [7:0] st_in;
        logic [7:0] wdata;
        logic       err;
        logic       stwe;
        logic [7:0] stat;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic preload(input int idx, input logic [7:0] val);
        @(negedge clk_i);
        load_en  = 1'b1;
        load_idx = idx;
        load_val = val;
        @(posedge clk_i);
        #1 load_en = 1'b0;
    endtask

    function automatic logic [39:0] mem_flat();
        return {rf_mem[4], rf_mem[3], rf_mem[2], rf_mem[1], rf_mem[0]};
    endfunction

    task automatic run_op(input vec_t v, input string tag);
        logic        legal;
        logic [7:0]  exp_mem [5];
        logic        e_stwe;
        logic [7:0]  e_stat;
        legal = (int'(v.src) < 5) && (int'(v.dst) < 5);
        if (int'(v.src) < 5) preload(int'(v.src), v.init);
`ifdef RF_SEQ_FLAGS_EN
        e_stwe = v.stwe;
        e_stat = v.stat;
`else
        e_stwe = 1'b0;
        e_stat = 8'h00;
`endif
        for (int i = 0; i < 5; i++) exp_mem[i] = rf_mem[i];
        if (legal) exp_mem[int'(v.dst)] = v.wdata;
        @(negedge clk_i);
        req_valid_i = 1'b1;
        req_op_i    = v.op;
        req_src_i   = v.src;
        req_dst_i   = v.dst;
        status_i    = v.st_in;
        @(posedge clk_i);
        #1 req_valid_i = 1'b0;
        chk({tag, " read busy/ready/done"}, {37'd0, busy_o, req_ready_o, done_o}, {37'd0, 3'b100});
        chk({tag, " read addr"}, {37'd0, rf_addr_o}, legal ? {37'd0, v.src} : 40'd0);
        @(posedge clk_i);
        #1;
        chk({tag, " write done/err/we"}, {37'd0, done_o, err_o, rf_we_o},
            {37'd0, 1'b1, v.err, !v.err});
        chk({tag, " write addr"}, {37'd0, rf_addr_o}, legal ? {37'd0, v.dst} : 40'd0);
        if (legal) chk({tag, " wdata"}, {32'd0, rf_wdata_o}, {32'd0, v.wdata});
        chk({tag, " status"}, {31'd0, status_we_o, status_o}, {31'd0, e_stwe, e_stat});
        @(posedge clk_i);
        #1;
        chk({tag, " idle busy/done"}, {38'd0, busy_o, done_o}, 40'd0);
        chk({tag, " rf contents"}, mem_flat(),
            {exp_mem[4], exp_mem[3], exp_mem[2], exp_mem[1], exp_mem[0]});
    endtask

    initial begin
        for (int i = 0; i < 5; i++) rf_mem[i] = 8'h00;
        //               op      src                dst                init   st_in  wdata  err   stwe  stat
        vecs[0] = '{OP_INC, REG_X,             REG_X,             8'h00, 8'h00, 8'h01, 1'b0, 1'b1, 8'h00};
        vecs[1] = '{OP_DEC, REG_Y,             REG_Y,             8'h00, 8'h27, 8'hFF, 1'b0, 1'b1, 8'hA5};
        vecs[2] = '{OP_MOV, REG_A,             REG_S,             8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00};
        vecs[3] = '{OP_MOV, REG_A,             REG_X,             8'h00, 8'h80, 8'h00, 1'b0, 1'b1, 8'h02};
        vecs[4] = '{OP_INC, reg_id_t'(3'd6),   REG_A,             8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00};
        vecs[5] = '{OP_INC, REG_T,             REG_T,             8'hFF, 8'h00, 8'h00, 1'b0, 1'b1, 8'h02};
        vecs[6] = '{OP_RSV, REG_T,             REG_A,             8'h5A, 8'hFF, 8'h5A, 1'b0, 1'b1, 8'h7D};
        vecs[7] = '{OP_MOV, REG_A,             reg_id_t'(3'd5),   8'h33, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00};
        vecs[8] = '{OP_DEC, REG_X,             REG_X,             8'h01, 8'hFF, 8'h00, 1'b0, 1'b1, 8'h7F};

        #12;
        chk("in-reset outputs", {29'd0, busy_o, done_o, err_o, rf_we_o, status_we_o, rf_addr_o},
            40'd0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        @(posedge clk_i);
        #1;
        chk("post-reset ready/busy", {38'd0, req_ready_o, busy_o}, {38'd0, 2'b10});
        chk("post-reset wdata/status", {24'd0, rf_wdata_o, status_o}, 40'd0);

        for (int i = 0; i < 9; i++) run_op(vecs[i], $sformatf("v%0d", i));

        // back-to-back INC X with valid held through the WRITE cycle
        preload(1, 8'h00);
        @(negedge clk_i);
        req_valid_i = 1'b1;
        req_op_i    = OP_INC;
        req_src_i   = REG_X;
        req_dst_i   = REG_X;
        status_i    = 8'h00;
        @(posedge clk_i);
        #1 chk("b2b c1 ready", {39'd0, req_ready_o}, 40'd0);
        @(posedge clk_i);
        #1 chk("b2b c2 done/ready/wdata", {30'd0, done_o, req_ready_o, rf_wdata_o},
               {30'd0, 2'b11, 8'h01});
        @(posedge clk_i);
        #1 chk("b2b c3 read", {34'd0, done_o, busy_o, req_ready_o, rf_addr_o},
               {34'd0, 3'b010, 3'd1});
        req_valid_i = 1'b0;
        @(posedge clk_i);
        #1 chk("b2b c4 done/wdata", {31'd0, done_o, rf_wdata_o}, {31'd0, 1'b1, 8'h02});
        @(posedge clk_i);
        #1 chk("b2b final X", {32'd0, rf_mem[1]}, {32'd0, 8'h02});
        chk("b2b idle", {38'd0, busy_o, done_o}, 40'd0);

        // reset asserted during READ of INC A
        preload(0, 8'h10);
        @(negedge clk_i);
        req_valid_i = 1'b1;
        req_op_i    = OP_INC;
        req_src_i   = REG_A;
        req_dst_i   = REG_A;
        @(posedge clk_i);
        #1 req_valid_i = 1'b0;
        chk("rst-mid in read", {39'd0, busy_o}, {39'd0, 1'b1});
        rstn_i = 1'b0;
        #1 chk("rst-mid outputs", {29'd0, busy_o, done_o, err_o, rf_we_o, status_we_o, rf_addr_o},
               40'd0);
        @(posedge clk_i);
        #1 chk("rst-mid no done", {38'd0, done_o, rf_we_o}, 40'd0);
        @(posedge clk_i);
        #1 chk("rst-mid A unchanged", {32'd0, rf_mem[0]}, {32'd0, 8'h10});
        @(negedge clk_i);
        rstn_i = 1'b1;
        @(posedge clk_i);
        #1 chk("rst-mid idle after release", {38'd0, req_ready_o, busy_o}, {38'd0, 2'b10});
        run_op('{OP_MOV, REG_A, REG_Y, 8'h10, 8'h00, 8'h10, 1'b0, 1'b1, 8'h00}, "post-rst mov");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
